// File: rtl/basic_ram_core.sv
// basic_ram_core: byte-addressed single-port RAM with cs/we/oe request and mem_done_out 4-phase handshake.
module basic_ram_core #(
    parameter int    ADDR_W    = 14,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = "ram.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_input,
    output logic [31:0]       data_output,
    output logic              mem_done_out,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [1:0]        data_size
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]        size_q, size_d;
    logic              wr_q, wr_d, done_q, done_d, mem_we;
    logic [31:0]       word, rd_val, wr_val;
    logic [3:0]        be;
    logic              byte_op, half_op;
    logic [31:0]       mem [2**(ADDR_W-2)];
    always_comb begin
        byte_op = size_q == 2'b00;
        half_op = size_q == 2'b01;
        word    = mem[addr_q[ADDR_W-1:2]];
        be      = byte_op ? 4'b0001 << addr_q[1:0] : half_op ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wr_val  = byte_op ? {4{wdata_q[7:0]}} : half_op ? {2{wdata_q[15:0]}} : wdata_q;
        rd_val  = byte_op ? {24'd0, word[{addr_q[1:0], 3'b000} +: 8]}
                : half_op ? {16'd0, word[{addr_q[1], 4'b0000} +: 16]} : word;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: if (cs && (we || oe)) begin
                addr_d  = address;
                wdata_d = data_input;
                size_d  = data_size;
                wr_d    = we;
                cnt_d   = 4'(LATENCY - 1);
                state_d = BUSY;
            end
            BUSY: if (!cs) state_d = IDLE;
            else if (cnt_q == 4'd0) begin
                state_d = ACK;
                done_d  = 1'b1;
                mem_we  = wr_q;
                rdata_d = wr_q ? rdata_q : rd_val;
            end else cnt_d = cnt_q - 4'd1;
            ACK: if (!cs) begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wr_val[8*i +: 8];
    end
    assign data_output  = rdata_q;
    assign mem_done_out = done_q;
endmodule

// File: tb/tb_basic_ram_core.sv
// tb_basic_ram_core: directed vector table, handshake corner cases and randomized traffic vs a byte-array model.
module tb_basic_ram_core;
    logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b0, we = 1'b0, oe = 1'b0;
    logic [13:0] address = '0;
    logic [31:0] data_input = '0, data_output;
    logic [1:0]  data_size = '0;
    logic        mem_done_out;
    int          n_cmp = 0, n_bad = 0;

    basic_ram_core #(.ADDR_W(14), .LATENCY(2), .INIT_FILE("ram.hex")) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_input(data_input),
        .data_output(data_output), .mem_done_out(mem_done_out), .cs(cs), .we(we),
        .oe(oe), .data_size(data_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [13:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t        tbl[18];
    logic [7:0]  rm[256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic [1:0] sz, input logic [13:0] a,
                          input logic [31:0] d, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        cs = 1'b1; we = w; oe = !w; data_size = sz; address = a; data_input = d;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (mem_done_out) break;
        end
        chk("latency", 32'(lat), 32'd2);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; oe = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", {31'd0, mem_done_out}, 32'd0);
        rd = data_output;
    endtask

    function automatic int sz_bytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    initial begin
        logic [31:0] rd, last_rd, exp;
        logic [31:0] ld[64];
        int          held, seen, n, base;
        tbl[0]  = '{1'b1, 2'b11, 14'h0010, 32'hDEADBEEF, 32'h00000000};
        tbl[1]  = '{1'b0, 2'b11, 14'h0010, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b0, 2'b00, 14'h0010, 32'h0,        32'h000000EF};
        tbl[3]  = '{1'b0, 2'b00, 14'h0013, 32'h0,        32'h000000DE};
        tbl[4]  = '{1'b1, 2'b01, 14'h0012, 32'h00001234, 32'h000000DE};
        tbl[5]  = '{1'b0, 2'b11, 14'h0010, 32'h0,        32'h1234BEEF};
        tbl[6]  = '{1'b1, 2'b00, 14'h0011, 32'h000000AA, 32'h1234BEEF};
        tbl[7]  = '{1'b0, 2'b11, 14'h0010, 32'h0,        32'h1234AAEF};
        tbl[8]  = '{1'b0, 2'b01, 14'h0013, 32'h0,        32'h00001234};
        tbl[9]  = '{1'b1, 2'b11, 14'h0013, 32'h11223344, 32'h00001234};
        tbl[10] = '{1'b0, 2'b11, 14'h0010, 32'h0,        32'h11223344};
        tbl[11] = '{1'b1, 2'b11, 14'h3FFC, 32'hCAFEF00D, 32'h11223344};
        tbl[12] = '{1'b0, 2'b11, 14'h3FFF, 32'h0,        32'hCAFEF00D};
        tbl[13] = '{1'b0, 2'b10, 14'h0010, 32'h0,        32'h11223344};
        tbl[14] = '{1'b1, 2'b00, 14'h3FFF, 32'hFFFFFF77, 32'h11223344};
        tbl[15] = '{1'b0, 2'b11, 14'h3FFC, 32'h0,        32'h77FEF00D};
        tbl[16] = '{1'b1, 2'b10, 14'h0020, 32'hA5A55A5A, 32'h77FEF00D};
        tbl[17] = '{1'b0, 2'b00, 14'h0022, 32'h0,        32'h000000A5};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", data_output, 32'd0);
        chk("reset_done", {31'd0, mem_done_out}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            access(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, rd);
            chk($sformatf("vec[%0d]", i), rd, tbl[i].exp);
        end

        // Held cs after completion: inputs change but no second write may happen.
        access(1'b1, 2'b11, 14'h0044, 32'h44444444, rd);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; data_size = 2'b11; address = 14'h0040; data_input = 32'h00000001;
        @(posedge clk);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            seen = mem_done_out;
        end
        chk("hold_done_rise", 32'(seen), 32'd1);
        @(negedge clk);
        address = 14'h0044; data_input = 32'h00000BAD;
        held = 0;
        repeat (4) begin
            @(posedge clk); #1;
            held += mem_done_out;
        end
        chk("hold_done_held", 32'(held), 32'd4);
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("hold_done_drop", {31'd0, mem_done_out}, 32'd0);
        access(1'b0, 2'b11, 14'h0040, 32'h0, rd);
        chk("hold_rd40", rd, 32'h00000001);
        access(1'b0, 2'b11, 14'h0044, 32'h0, rd);
        chk("hold_rd44", rd, 32'h44444444);

        // Abort a write one cycle in.
        @(negedge clk);
        cs = 1'b1; we = 1'b1; data_size = 2'b11; address = 14'h0010; data_input = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            seen += mem_done_out;
        end
        chk("abort_done", 32'(seen), 32'd0);
        access(1'b0, 2'b11, 14'h0010, 32'h0, rd);
        chk("abort_mem", rd, 32'h11223344);

        // Reset in the middle of a read.
        @(negedge clk);
        cs = 1'b1; oe = 1'b1; data_size = 2'b11; address = 14'h0010;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dout", data_output, 32'd0);
        chk("rst_mid_done", {31'd0, mem_done_out}, 32'd0);
        cs = 1'b0; oe = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        access(1'b0, 2'b11, 14'h0010, 32'h0, rd);
        chk("rst_mem_kept", rd, 32'h11223344);

        // Loader flow.
        for (int i = 0; i < 64; i++) begin
            ld[i] = $urandom;
            access(1'b1, 2'b11, 14'(4 * i), ld[i], rd);
            for (int b = 0; b < 4; b++) rm[4*i+b] = ld[i][8*b +: 8];
        end
        for (int i = 0; i < 64; i++) begin
            access(1'b0, 2'b11, 14'(4 * i), 32'h0, rd);
            chk($sformatf("load[%0d]", i), rd, ld[i]);
        end
        last_rd = rd;

        // Random mixed-size traffic against the byte model.
        for (int t = 0; t < 150; t++) begin
            logic        w;
            logic [1:0]  sz;
            logic [13:0] a;
            logic [31:0] d;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 14'($urandom_range(0, 255));
            d  = $urandom;
            n  = sz_bytes(sz);
            base = int'(a) / n * n;
            access(w, sz, a, d, rd);
            if (w) begin
                for (int b = 0; b < n; b++) rm[base+b] = d[8*b +: 8];
                exp = last_rd;
            end else begin
                exp = 32'd0;
                for (int b = 0; b < n; b++) exp[8*b +: 8] = rm[base+b];
                last_rd = exp;
            end
            chk($sformatf("rand[%0d]", t), rd, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
